// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states
// and the op bit that separates multiply from divide.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // op[2] = 0 selects multiply.
  localparam int MDU_MUL_BIT = 2;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide.
// Retires BITS_PER_CYCLE steps per cycle; 'last' flags the final step.
module muldiv_iter #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_mul,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W     = DATA_WIDTH;
  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       sum, rsh;
  logic             ge;

  // hi holds the product high half / partial remainder; lo holds the
  // multiplier being consumed / dividend being replaced by quotient bits.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    sum   = '0;
    rsh   = '0;
    ge    = 1'b0;
    if (load) begin
      hi_d  = '0;
      lo_d  = op_a;
      b_d   = op_b;
      cnt_d = CNT_MAX;
    end else if (step) begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        if (is_mul) begin
          sum          = {1'b0, hi_d} + (lo_d[0] ? {1'b0, b_q} : '0);
          {hi_d, lo_d} = {sum, lo_d[W-1:1]};
        end else begin
          rsh  = {hi_d, lo_d[W-1]};
          ge   = (rsh >= {1'b0, b_q});
          hi_d = ge ? (rsh[W-1:0] - b_q) : rsh[W-1:0];
          lo_d = {lo_d[W-2:0], ge};
        end
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: valid N+1 cycles after start (1 for divide-by-zero
// and signed overflow); busy holds the pipeline, flush aborts the in-flight op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  logic                 neg_q, neg_d, neg_rem_q, neg_rem_d, fast_q, fast_d;
  logic [W-1:0]         fast_res_q, fast_res_d, res_q, res_d;

  op_t          op_in;
  logic         a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf, is_fast;
  logic         accept, commit, iter_last;
  logic [W-1:0] mag_a, mag_b, fast_val, calc_res, done_val, iter_hi, iter_lo;
  logic [2*W-1:0] prod, prod_fix;

  assign op_in    = op_t'(op);
  assign a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign neg_a    = a_signed && src_a[W-1];
  assign neg_b    = b_signed && src_b[W-1];
  assign mag_a    = neg_a ? -src_a : src_a;
  assign mag_b    = neg_b ? -src_b : src_b;
  assign div_zero = (src_b == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && src_a == MOST_NEG && src_b == '1;
  assign is_fast  = op_in[MDU_MUL_BIT] && (div_zero || div_ovf);
  assign accept   = (state_q == IDLE) && start && !flush;
  assign commit   = (state_q == DONE) && !flush;

  // Only divides reach the fast path, so REMU is the sole remaining case.
  always_comb begin
    case (op_in)
      OP_DIV:  fast_val = div_zero ? '1 : src_a;
      OP_DIVU: fast_val = '1;
      OP_REM:  fast_val = div_zero ? src_a : '0;
      default: fast_val = src_a;
    endcase
  end

  assign prod     = {iter_hi, iter_lo};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    case (op_q)
      OP_MUL:                       calc_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              calc_res = neg_q ? -iter_lo : iter_lo;
      default:                      calc_res = neg_rem_q ? -iter_hi : iter_hi;
    endcase
  end

  assign done_val = fast_q ? fast_res_q : calc_res;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    res_d      = res_q;
    tag_out_d  = tag_out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = op_in;
          tag_d      = tag_in;
          neg_d      = neg_a ^ neg_b;
          neg_rem_d  = neg_a;
          fast_d     = is_fast;
          fast_res_d = fast_val;
          state_d    = is_fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush)          state_d = IDLE;
        else if (iter_last) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (commit) begin
          res_d     = done_val;
          tag_out_d = tag_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      tag_q      <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      res_q      <= '0;
      tag_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
      res_q      <= res_d;
      tag_out_q  <= tag_out_d;
    end
  end

  muldiv_iter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept && !is_fast),
    .step  (state_q == CALC),
    .is_mul(!op_q[MDU_MUL_BIT]),
    .op_a  (mag_a),
    .op_b  (mag_b),
    .last  (iter_last),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  // A flushed DONE cycle must neither pulse valid nor disturb the visible result.
  assign busy    = (state_q != IDLE);
  assign valid   = commit;
  assign result  = commit ? done_val : res_q;
  assign tag_out = commit ? tag_q : tag_out_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. Sits beside the ALU in the Execute stage. Accepts one operation per start pulse and holds the pipeline via busy until the result is valid. Generalises the single-cycle ALU path: parametrised width and radix, multi-cycle operation, flush support and a destination-register tag passthrough.

Parameters:
DATA_WIDTH, 32, operand/result width; must be a power of two, at least 8.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; one of 1, 2, 4; must divide DATA_WIDTH.
TAG_WIDTH, 5, width of the destination-register tag carried with the operation.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only when busy=0
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  in  DATA_WIDTH  rs1 operand
src_b  in  DATA_WIDTH  rs2 operand
tag_in  in  TAG_WIDTH  destination register index
flush  in  1  abort the in-flight operation (branch/jump flush)
busy  out  1  operation in flight; the hazard logic stalls the pipeline on this
valid  out  1  one-cycle pulse: result/tag_out are valid
result  out  DATA_WIDTH  result; held until the next accepted start
tag_out  out  TAG_WIDTH  tag of the completed operation

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, valid=0, result=0, tag_out=0. Reset mid-operation discards the work; no valid pulse is produced.
- Let N = DATA_WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE -> CALC on start when not flushing. Operands, op and tag are latched. Signed operands are converted to magnitudes; result signs are recorded.
  - CALC runs for exactly N cycles, then -> DONE.
  - DONE: valid=1 for one cycle, result registered, then -> IDLE.
- Latency: start at cycle 0 gives valid at cycle N+1 (33 for the defaults).
- busy = (state != IDLE). A start while busy is ignored.
- Multiply: unsigned shift-add over 2*DATA_WIDTH bits, then sign fix-up.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncating division).
- Fast path, IDLE -> DONE directly with latency 1:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return src_a.
  - Signed overflow (src_a = most-negative, src_b = -1): DIV returns src_a; REM returns 0.
- flush:
  - In CALC or DONE: -> IDLE next cycle, valid stays 0, result unchanged.
  - flush and start in the same cycle: flush wins and the start is dropped.
- valid and a new start may coincide only once the unit has returned to IDLE (back-to-back spacing is N+2 cycles).

Decomposition:
- muldiv_pkg holds:
  - the op_t enum (funct3 encodings above),
  - the state_t enum (IDLE, CALC, DONE),
  - the MDU_MUL_BIT constant (op[2]=0 selects multiply).
- Sub-module muldiv_iter is the unsigned iterative datapath. It holds the accumulator/remainder register, the shift register and the iteration counter, and processes BITS_PER_CYCLE steps per cycle. muldiv_unit wraps it with sign handling, the fast path, the FSM and the tag.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD at cycle 0 -> busy=1 on cycles 1..33; valid at cycle 33; result=0xFFFFFFEB; tag_out=tag_in.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
- DIV 100/0 -> 0xFFFFFFFF with valid at cycle 1. REM 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- DIV started at cycle 0, flush at cycle 10 -> busy=0 at cycle 11, no valid, result keeps its prior value. A start asserted together with the flush is ignored. rst at cycle 5 of a MUL gives the same outcome, with result=0.
- Randomised ops with BITS_PER_CYCLE=1, 2 and 4 checked against a reference model. Latency for each is N+1 (33, 17, 9); a start issued while busy never alters the in-flight result.
